// File: rtl/serializer_pkg.sv
// Shared state encoding and default word width for the bit serializer.
package serializer_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_e;

endpackage

// File: rtl/bit_serializer.sv
// MSB-first parallel-to-serial converter with a valid/ready input handshake.
// Define BIT_SERIALIZER_PARITY_EN to append an even-parity bit after each word.
module bit_serializer
    import serializer_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             x,
    output logic             x_valid,
    output logic             busy
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               x_q, x_d;
    logic               xv_q, xv_d;
    logic               last_cycle;
    logic               accept;
`ifdef BIT_SERIALIZER_PARITY_EN
    logic               par_q, par_d;
`endif

    // Final emitted cycle of a word is the only non-idle slot that can take a new word.
`ifdef BIT_SERIALIZER_PARITY_EN
    assign last_cycle = (state_q == PARITY);
`else
    assign last_cycle = (state_q == SHIFT) && (cnt_q == '0);
`endif

    assign in_ready = (state_q == IDLE) || last_cycle;
    assign accept   = in_valid && in_ready;
    assign x        = x_q;
    assign x_valid  = xv_q;
    assign busy     = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        x_d     = 1'b0;
        xv_d    = 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
        par_d   = par_q;
`endif
        if (accept) begin
            state_d = SHIFT;
            x_d     = in_data[WIDTH-1];
            xv_d    = 1'b1;
            shreg_d = {in_data[WIDTH-2:0], 1'b0};
            cnt_d   = CNT_W'(WIDTH - 1);
`ifdef BIT_SERIALIZER_PARITY_EN
            par_d   = ^in_data;
`endif
        end else begin
            case (state_q)
                IDLE: ;
                SHIFT: begin
                    if (cnt_q == '0) begin
`ifdef BIT_SERIALIZER_PARITY_EN
                        state_d = PARITY;
                        x_d     = par_q;
                        xv_d    = 1'b1;
`else
                        state_d = IDLE;
`endif
                    end else begin
                        // shreg holds the not-yet-emitted bits left-aligned
                        x_d     = shreg_q[WIDTH-1];
                        xv_d    = 1'b1;
                        shreg_d = shreg_q << 1;
                        cnt_d   = cnt_q - CNT_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            x_q     <= 1'b0;
            xv_q    <= 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            xv_q    <= xv_d;
`ifdef BIT_SERIALIZER_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer at WIDTH=8 and WIDTH=2; follows BIT_SERIALIZER_PARITY_EN.
module tb_bit_serializer;

    logic       clk;
    logic       rst;
    logic [7:0] in_data8;
    logic       in_valid8;
    logic       in_ready8, x8, xv8, busy8;
    logic [1:0] in_data2;
    logic       in_valid2;
    logic       in_ready2, x2, xv2, busy2;

    int n_cmp = 0;
    int n_err = 0;

    bit_serializer #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_data(in_data8), .in_valid(in_valid8),
        .in_ready(in_ready8), .x(x8), .x_valid(xv8), .busy(busy8)
    );

    bit_serializer #(.WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .in_data(in_data2), .in_valid(in_valid2),
        .in_ready(in_ready2), .x(x2), .x_valid(xv2), .busy(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Compare all WIDTH=8 outputs at a falling edge, then set inputs for the next rising edge.
    task automatic step(input string tag, input logic ex, input logic exv, input logic eb,
                        input logic er, input logic nv, input logic [7:0] nd);
        check({tag, ".x"},        32'(x8),        32'(ex));
        check({tag, ".x_valid"},  32'(xv8),       32'(exv));
        check({tag, ".busy"},     32'(busy8),     32'(eb));
        check({tag, ".in_ready"}, 32'(in_ready8), 32'(er));
        in_valid8 = nv;
        in_data8  = nd;
        @(negedge clk);
    endtask

    // Expect one accepted word on x, MSB first, while holding the next word on the inputs.
    task automatic word_bits(input string tag, input logic [7:0] w, input logic nv,
                             input logic [7:0] nd);
        for (int i = 0; i < 8; i++) begin
            logic rdy;
`ifdef BIT_SERIALIZER_PARITY_EN
            rdy = 1'b0;
`else
            rdy = (i == 7);
`endif
            step($sformatf("%s.b%0d", tag, i), w[7-i], 1'b1, 1'b1, rdy, nv, nd);
        end
`ifdef BIT_SERIALIZER_PARITY_EN
        step({tag, ".par"}, ^w, 1'b1, 1'b1, 1'b1, nv, nd);
`endif
    endtask

    initial begin
        rst       = 1'b0;
        in_valid8 = 1'b0;
        in_data8  = '0;
        in_valid2 = 1'b0;
        in_data2  = '0;

        // Reset state
        @(negedge clk);
        step("rst0", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        rst = 1'b1;

        // Single word accepted on the first edge after reset release
        step("idle_c6", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hC6);
        word_bits("c6", 8'hC6, 1'b0, 8'h00);
        step("after_c6", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        step("idle2", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);

        // Back-to-back FF then 00 with no gap
        step("idle_ff", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hFF);
        word_bits("ff", 8'hFF, 1'b1, 8'h00);
        word_bits("00", 8'h00, 1'b0, 8'h00);
        step("after_b2b", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);

        // Backpressure: A5 presented throughout the 3C word
        step("idle_3c", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h3C);
        word_bits("3c", 8'h3C, 1'b1, 8'hA5);
        word_bits("a5", 8'hA5, 1'b0, 8'h00);
        step("after_a5", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);

        // D6 (odd weight) and C6 (even weight) back-to-back
        step("idle_d6", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hD6);
        word_bits("d6", 8'hD6, 1'b1, 8'hC6);
        word_bits("c6b", 8'hC6, 1'b0, 8'h00);
        step("after_d6c6", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);

        // Reset mid-word discards the partial word
        step("idle_5a", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h5A);
        step("5a.b0", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        rst = 1'b0;
        #1;
        check("rst_mid.x",        32'(x8),        32'd0);
        check("rst_mid.x_valid",  32'(xv8),       32'd0);
        check("rst_mid.busy",     32'(busy8),     32'd0);
        check("rst_mid.in_ready", 32'(in_ready8), 32'd1);
        @(negedge clk);
        step("rst_hold1", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        step("rst_hold2", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        rst = 1'b1;
        for (int i = 0; i < 4; i++)
            step($sformatf("post_rst%0d", i), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);

        // WIDTH=2: accept 2'b10
        in_valid2 = 1'b1;
        in_data2  = 2'b10;
        @(negedge clk);
        check("w2.b0.x",        32'(x2),        32'd1);
        check("w2.b0.x_valid",  32'(xv2),       32'd1);
        check("w2.b0.busy",     32'(busy2),     32'd1);
        check("w2.b0.in_ready", 32'(in_ready2), 32'd0);
        in_valid2 = 1'b0;
        in_data2  = 2'b00;
        @(negedge clk);
        check("w2.b1.x",        32'(x2),        32'd0);
        check("w2.b1.x_valid",  32'(xv2),       32'd1);
`ifdef BIT_SERIALIZER_PARITY_EN
        check("w2.b1.in_ready", 32'(in_ready2), 32'd0);
        @(negedge clk);
        check("w2.par.x",       32'(x2),        32'd1);
        check("w2.par.x_valid", 32'(xv2),       32'd1);
`endif
        check("w2.last.in_ready", 32'(in_ready2), 32'd1);
        @(negedge clk);
        check("w2.idle.x",       32'(x2),    32'd0);
        check("w2.idle.x_valid", 32'(xv2),   32'd0);
        check("w2.idle.busy",    32'(busy2), 32'd0);
        @(negedge clk);
        check("w2.idle2.x_valid", 32'(xv2), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bit_serializer.md
BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning the parallel word width in bits (legal range 2..32).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port in_data, input, WIDTH bits: parallel word to serialize.
REQ-005 SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-006 SHALL have port in_ready, output, 1 bit: block can accept a word this cycle.
REQ-007 SHALL have port x, output, 1 bit: serial bit stream feeding the downstream Moore sequence detector.
REQ-008 SHALL have port x_valid, output, 1 bit: x carries a payload or parity bit this cycle.
REQ-009 SHALL have port busy, output, 1 bit: a word is in flight.

Function
REQ-010 SHALL implement a state machine with states IDLE, SHIFT and PARITY; PARITY exists only with the macro of REQ-024.
REQ-011 SHALL accept a word on a rising edge when in_valid and in_ready are both 1; in_data is captured into a WIDTH-bit shift register.
REQ-012 SHALL drive in_ready as a combinational function of state: 1 in IDLE, 1 in the final bit cycle of a word, 0 otherwise.
REQ-013 SHALL register x: on the accepting edge, x <= in_data[WIDTH-1], x_valid <= 1, and the state goes to SHIFT; latency is 1 cycle from acceptance to the MSB on x.
REQ-014 SHALL present bits MSB first, one per clock, for exactly WIDTH consecutive cycles with no gaps; a down-counter of $clog2(WIDTH) bits tracks the bits remaining.
REQ-015 SHALL, after the LSB cycle with no new acceptance, return to IDLE with x = 0 and x_valid = 0. x is held low while idle so the downstream detector sees zeros.
REQ-016 SHALL, on acceptance during the final bit cycle (back-to-back), load the new word and drive its MSB on the next cycle, so the stream has zero idle cycles between words.
REQ-017 SHALL ignore in_valid while in_ready = 0; the upstream source holds in_data and in_valid stable until acceptance.
REQ-018 SHALL drive busy = 1 in SHIFT and PARITY, and busy = 0 in IDLE.
REQ-019 SHALL not change in_data capture or the bit order in response to any input mid-word; only reset aborts a word.

Reset
REQ-020 SHALL, while rst = 0, immediately force the state to IDLE, x = 0, x_valid = 0, busy = 0, and clear the shift register and counter.
REQ-021 SHALL drive in_ready = 1 during and after reset (IDLE) and accept a word on the first rising edge after rst deasserts.
REQ-022 SHALL, on reset asserted mid-word, discard the partial word; no residual bits are emitted after release.

Configuration
REQ-023 SHALL use the macro BIT_SERIALIZER_PARITY_EN.
REQ-024 SHALL, when BIT_SERIALIZER_PARITY_EN is defined, follow the LSB cycle with one PARITY cycle that drives x = the even-parity bit (XOR of the captured word) with x_valid = 1. In this mode the final bit cycle for REQ-012/016 is the PARITY cycle.
REQ-025 SHALL, when BIT_SERIALIZER_PARITY_EN is undefined, omit the PARITY state, giving exactly WIDTH bit cycles per word.

Structure
REQ-026 SHALL place the state encoding constants (IDLE=0, SHIFT=1, PARITY=2, 2 bits) and the default WIDTH in shared package serializer_pkg.
REQ-027 SHALL be a single module; the parity computation is an inline reduction, and a sub-module is not natural here.

Verification
REQ-028 Reset: hold rst=0 mid-word for 2 cycles -> x=0, x_valid=0, busy=0, in_ready=1; no stray bits after release.
REQ-029 Single word, no parity: accept 8'hC6 -> x = 1,1,0,0,0,1,1,0 on 8 consecutive cycles with x_valid=1, then x=0, x_valid=0, busy=0; an attached sequence detector asserts z once.
REQ-030 Back-to-back: in_valid held with 8'hFF then 8'h00 -> 16 contiguous valid bits (eight 1s then eight 0s), in_ready=1 only in bit cycle 8 and IDLE.
REQ-031 Backpressure: in_valid=1 with 8'hA5 while busy -> not accepted until the final bit cycle; word emitted intact as 1,0,1,0,0,1,0,1.
REQ-032 Parity enabled: accept 8'hD6 -> 1,1,0,1,0,1,1,0 then parity bit 1 (9 valid cycles); accept 8'hC6 -> parity bit 0.
REQ-033 WIDTH=2: accept 2'b10 -> x = 1,0, then idle; counter wrap is correct.
